dcache_dirty_tracker: RTL and testbench

Parametrised per-line dirty-bit tracker for the L1 data cache. It sits beside the tag/data arrays and records which lines hold modified data. It provides:
- a registered dirty read for victim selection
- NWR store-hit set ports, an insert port and a clear port
- a built-in flush sequencer that walks all lines and hands each dirty line index to the writeback path over a valid/ready handshake

---
 rtl/dcache_dirty_pkg.sv | 14 +
 rtl/dcache_dirty_find.sv | 27 ++
 rtl/dcache_dirty_tracker.sv | 154 +++++++++++++++
 tb/tb_dcache_dirty_tracker.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_dirty_pkg.sv
// Shared flush-sequencer states and default geometry for the L1 dirty-bit tracker.
package dcache_dirty_pkg;

    localparam int DCACHE_DIRTY_ADDR_WIDTH = 6;
    localparam int DCACHE_DIRTY_NWR        = 2;

    typedef enum logic [1:0] {
        IDLE,
        SEEK,
        OFFER,
        DONE
    } flush_state_e;

endpackage

// File: rtl/dcache_dirty_find.sv
// Combinational finder: lowest set bit of vec whose index is >= cursor.
module dcache_dirty_find
    import dcache_dirty_pkg::*;
#(
    parameter int ADDR_WIDTH = DCACHE_DIRTY_ADDR_WIDTH
) (
    input  logic [(1 << ADDR_WIDTH)-1:0] vec,
    input  logic [ADDR_WIDTH:0]          cursor,
    output logic                         found,
    output logic [ADDR_WIDTH-1:0]        idx
);

    localparam int N = 1 << ADDR_WIDTH;

    // Descending walk so the last hit written is the lowest qualifying index.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i] && ((ADDR_WIDTH + 1)'(i) >= cursor)) begin
                found = 1'b1;
                idx   = ADDR_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/dcache_dirty_tracker.sv
// Per-line dirty-bit tracker with registered read and a flush sweep sequencer.
// Optional write-to-read bypass is enabled by defining DCACHE_DIRTY_BYPASS_EN.
module dcache_dirty_tracker
    import dcache_dirty_pkg::*;
#(
    parameter int ADDR_WIDTH = DCACHE_DIRTY_ADDR_WIDTH,
    parameter int NWR        = DCACHE_DIRTY_NWR
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDR_WIDTH-1:0]     read_addr0,
    input  logic                      read_clkEn0,
    output logic                      read_dirty0,
    input  logic [NWR*ADDR_WIDTH-1:0] write_addr,
    input  logic [NWR-1:0]            write_wen,
    input  logic                      insert,
    input  logic [ADDR_WIDTH-1:0]     insert_addr,
    input  logic                      insert_dirty,
    input  logic                      clear_wen,
    input  logic [ADDR_WIDTH-1:0]     clear_addr,
    input  logic                      init,
    input  logic                      flush_req,
    output logic                      flush_valid,
    output logic [ADDR_WIDTH-1:0]     flush_addr,
    input  logic                      flush_ready,
    output logic                      flush_busy,
    output logic                      flush_done
);

    localparam int N = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_LINE = ADDR_WIDTH'(N - 1);

    logic [N-1:0]          dirty;
    logic [N-1:0]          dirty_next;
    logic [N-1:0]          set_vec;
    logic [N-1:0]          clr_vec;
    logic                  flush_acc;
    logic                  read_dirty_p1;
    flush_state_e          state;
    logic [ADDR_WIDTH:0]   cursor;
    logic                  find_found;
    logic [ADDR_WIDTH-1:0] find_idx;

    assign flush_acc   = (state == OFFER) && flush_ready;
    assign read_dirty0 = read_dirty_p1;

    // Sets are OR-ed in after clears, so a set always wins on a shared index.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        for (int p = 0; p < NWR; p++) begin
            if (write_wen[p]) begin
                set_vec[write_addr[p*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b1;
            end
        end
        if (insert) begin
            if (insert_dirty) begin
                set_vec[insert_addr] = 1'b1;
            end else begin
                clr_vec[insert_addr] = 1'b1;
            end
        end
        if (clear_wen) begin
            clr_vec[clear_addr] = 1'b1;
        end
        if (flush_acc) begin
            clr_vec[flush_addr] = 1'b1;
        end
        dirty_next = init ? '0 : ((dirty & ~clr_vec) | set_vec);
    end

    dcache_dirty_find #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_find (
        .vec    (dirty),
        .cursor (cursor),
        .found  (find_found),
        .idx    (find_idx)
    );

    // Stage p1: dirty storage update and registered read port
    always_ff @(posedge clk) begin
        if (rst) begin
            dirty         <= '0;
            read_dirty_p1 <= 1'b0;
        end else begin
            dirty <= dirty_next;
            if (read_clkEn0) begin
`ifdef DCACHE_DIRTY_BYPASS_EN
                read_dirty_p1 <= dirty_next[read_addr0];
`else
                read_dirty_p1 <= dirty[read_addr0];
`endif
            end
        end
    end

    // Flush sequencer; init during a sweep short-circuits straight to DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cursor      <= '0;
            flush_valid <= 1'b0;
            flush_addr  <= '0;
            flush_busy  <= 1'b0;
            flush_done  <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush_req) begin
                        state      <= SEEK;
                        cursor     <= '0;
                        flush_busy <= 1'b1;
                    end
                end
                SEEK: begin
                    if (init || !find_found) begin
                        state      <= DONE;
                        flush_done <= 1'b1;
                    end else begin
                        state       <= OFFER;
                        flush_addr  <= find_idx;
                        flush_valid <= 1'b1;
                    end
                end
                OFFER: begin
                    if (init) begin
                        state       <= DONE;
                        flush_valid <= 1'b0;
                        flush_done  <= 1'b1;
                    end else if (flush_ready) begin
                        flush_valid <= 1'b0;
                        cursor      <= {1'b0, flush_addr} + (ADDR_WIDTH + 1)'(1);
                        if (flush_addr == LAST_LINE) begin
                            state      <= DONE;
                            flush_done <= 1'b1;
                        end else begin
                            state <= SEEK;
                        end
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    flush_busy <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_dirty_tracker.sv
// Scoreboard bench for dcache_dirty_tracker: stimulus queues expectations, a monitor pops and compares.
module tb_dcache_dirty_tracker;

    localparam int AW       = 6;
    localparam int NWR      = 2;
    localparam int DONE_TAG = 1000;

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     read_addr0;
    logic              read_clkEn0;
    logic              read_dirty0;
    logic [NWR*AW-1:0] write_addr;
    logic [NWR-1:0]    write_wen;
    logic              insert;
    logic [AW-1:0]     insert_addr;
    logic              insert_dirty;
    logic              clear_wen;
    logic [AW-1:0]     clear_addr;
    logic              init;
    logic              flush_req;
    logic              flush_valid;
    logic [AW-1:0]     flush_addr;
    logic              flush_ready;
    logic              flush_busy;
    logic              flush_done;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int rd_exp_q[$];
    int fl_exp_q[$];
    bit rd_pend  = 1'b0;

    always #5 clk = ~clk;

    dcache_dirty_tracker #(
        .ADDR_WIDTH(AW),
        .NWR       (NWR)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .read_addr0  (read_addr0),
        .read_clkEn0 (read_clkEn0),
        .read_dirty0 (read_dirty0),
        .write_addr  (write_addr),
        .write_wen   (write_wen),
        .insert      (insert),
        .insert_addr (insert_addr),
        .insert_dirty(insert_dirty),
        .clear_wen   (clear_wen),
        .clear_addr  (clear_addr),
        .init        (init),
        .flush_req   (flush_req),
        .flush_valid (flush_valid),
        .flush_addr  (flush_addr),
        .flush_ready (flush_ready),
        .flush_busy  (flush_busy),
        .flush_done  (flush_done)
    );

    task automatic check(input string name, input int act, input int exp);
        chk_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic unexpected(input string name, input int act);
        chk_cnt++;
        $display("FAIL %s: got unexpected output %0d, expected none", name, act);
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_pend) begin
                if (rd_exp_q.size() == 0) unexpected("read_dirty0", int'(read_dirty0));
                else check("read_dirty0", int'(read_dirty0), rd_exp_q.pop_front());
            end
            rd_pend = read_clkEn0 && !rst;
            if (flush_valid && flush_ready) begin
                if (fl_exp_q.size() == 0) unexpected("flush_addr", int'(flush_addr));
                else check("flush_addr", int'(flush_addr), fl_exp_q.pop_front());
            end
            if (flush_done) begin
                if (fl_exp_q.size() == 0) unexpected("flush_done", DONE_TAG);
                else check("flush_done", DONE_TAG, fl_exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        write_wen = '0;
        insert    = 1'b0;
        clear_wen = 1'b0;
        init      = 1'b0;
        flush_req = 1'b0;
    endtask

    task automatic set_port(input int p, input int a);
        write_wen[p]            = 1'b1;
        write_addr[p*AW +: AW]  = AW'(a);
    endtask

    task automatic read_line(input int a, input int exp);
        read_clkEn0 = 1'b1;
        read_addr0  = AW'(a);
        rd_exp_q.push_back(exp);
        tick();
        read_clkEn0 = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (flush_busy && n < 200) begin
            tick();
            n++;
        end
        check(name, int'(flush_busy), 0);
    endtask

    initial begin
        rst = 1'b1; read_addr0 = '0; read_clkEn0 = 1'b0; write_addr = '0;
        insert_addr = '0; insert_dirty = 1'b0; clear_addr = '0; flush_ready = 1'b0;
        idle_inputs();
        repeat (3) tick();
        rst = 1'b0;
        check("rst_read_dirty0", int'(read_dirty0), 0);
        check("rst_flush_valid", int'(flush_valid), 0);
        check("rst_flush_addr", int'(flush_addr), 0);
        check("rst_flush_busy", int'(flush_busy), 0);
        check("rst_flush_done", int'(flush_done), 0);

        // Two store-hit ports, then reads
        set_port(0, 5); set_port(1, 40); tick(); idle_inputs();
        read_line(5, 1);
        read_line(6, 0);
        read_line(40, 1);
        tick(); tick();
        check("read_hold", int'(read_dirty0), 1);

        // Set beats clear on the same index
        insert = 1'b1; insert_addr = 6'd9; insert_dirty = 1'b0; set_port(0, 9);
        tick(); idle_inputs();
        read_line(9, 1);
        clear_wen = 1'b1; clear_addr = 6'd9; tick(); idle_inputs();
        read_line(9, 0);

        // Sweep over {3,17,63} with ready tied high
        init = 1'b1; tick(); idle_inputs();
        read_line(40, 0);
        set_port(0, 3); set_port(1, 17); tick(); idle_inputs();
        insert = 1'b1; insert_addr = 6'd63; insert_dirty = 1'b1; tick(); idle_inputs();
        flush_ready = 1'b1;
        fl_exp_q.push_back(3); fl_exp_q.push_back(17); fl_exp_q.push_back(63); fl_exp_q.push_back(DONE_TAG);
        flush_req = 1'b1; tick(); flush_req = 1'b0;
        check("busy_on", int'(flush_busy), 1);
        wait_idle("sweep3_end");
        flush_ready = 1'b0;
        read_line(3, 0);
        read_line(17, 0);
        read_line(63, 0);

        // Back-pressure, then store in the accept cycle
        set_port(0, 4); tick(); idle_inputs();
        fl_exp_q.push_back(4); fl_exp_q.push_back(DONE_TAG);
        flush_req = 1'b1; tick(); flush_req = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", int'(flush_valid), 1);
            check("hold_addr", int'(flush_addr), 4);
            tick();
        end
        flush_ready = 1'b1; set_port(0, 4); tick();
        flush_ready = 1'b0; idle_inputs();
        wait_idle("sweep4_end");
        read_line(4, 1);

        // init during OFFER forces DONE
        init = 1'b1; tick(); idle_inputs();
        set_port(0, 20); set_port(1, 30); tick(); idle_inputs();
        flush_req = 1'b1; tick(); flush_req = 1'b0;
        tick();
        check("offer20_valid", int'(flush_valid), 1);
        check("offer20_addr", int'(flush_addr), 20);
        fl_exp_q.push_back(DONE_TAG);
        init = 1'b1; tick(); init = 1'b0;
        check("init_done", int'(flush_done), 1);
        check("init_valid", int'(flush_valid), 0);
        tick();
        check("init_idle", int'(flush_busy), 0);
        read_line(20, 0);
        read_line(30, 0);

        // rst mid-sweep aborts without flush_done
        set_port(0, 7); tick(); idle_inputs();
        read_line(7, 1);
        flush_req = 1'b1; tick(); flush_req = 1'b0;
        tick();
        check("offer7_addr", int'(flush_addr), 7);
        rst = 1'b1; tick(); rst = 1'b0;
        check("abort_busy", int'(flush_busy), 0);
        check("abort_valid", int'(flush_valid), 0);
        check("abort_addr", int'(flush_addr), 0);
        check("abort_read", int'(read_dirty0), 0);
        repeat (4) tick();
        read_line(7, 0);

        // Read coinciding with a set, then with a clear, at the same index
        read_clkEn0 = 1'b1; read_addr0 = 6'd12; set_port(0, 12);
`ifdef DCACHE_DIRTY_BYPASS_EN
        rd_exp_q.push_back(1);
`else
        rd_exp_q.push_back(0);
`endif
        tick(); read_clkEn0 = 1'b0; idle_inputs();
        read_line(12, 1);
        read_clkEn0 = 1'b1; read_addr0 = 6'd12; clear_wen = 1'b1; clear_addr = 6'd12;
`ifdef DCACHE_DIRTY_BYPASS_EN
        rd_exp_q.push_back(0);
`else
        rd_exp_q.push_back(1);
`endif
        tick(); read_clkEn0 = 1'b0; idle_inputs();
        read_line(12, 0);

        repeat (3) tick();
        check("read_queue_drained", rd_exp_q.size(), 0);
        check("flush_queue_drained", fl_exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
